vx_warp_perf_tracker: RTL and testbench

//  Per-core scheduler/warp performance accumulator; successor to the fixed schedule-side perf counters.

---
 rtl/vx_warp_perf_tracker_pkg.sv | 33 +++
 rtl/vx_warp_perf_tracker_if.sv | 31 +++
 rtl/vx_warp_perf_tracker_sat_accum.sv | 52 +++++
 rtl/vx_warp_perf_tracker.sv | 195 +++++++++++++++++++
 tb/tb_vx_warp_perf_tracker.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vx_warp_perf_tracker_pkg.sv
// vx_warp_perf_tracker_pkg
//   Shared types and helpers for the warp performance tracker.
//   - MAX_WARPS / MAX_PW : widest warp mask supported by the popcount helper
//   - perf_inc_t         : per-cycle increments derived from one sampled cycle
//   - pop_width()        : popcount result width for a given warp count
//   - popcount()         : number of set bits in a (zero-extended) warp mask
package vx_warp_perf_tracker_pkg;

  localparam int unsigned MAX_WARPS = 64;
  localparam int unsigned MAX_PW    = 7;

  // One sampled cycle's contribution to the four lifetime totals.
  typedef struct packed {
    logic              idle;
    logic              stall;
    logic [MAX_PW-1:0] active;
    logic [MAX_PW-1:0] stalled;
  } perf_inc_t;

  function automatic int unsigned pop_width(input int unsigned num_warps);
    return $clog2(num_warps + 1);
  endfunction

  function automatic logic [MAX_PW-1:0] popcount(input logic [MAX_WARPS-1:0] bits);
    logic [MAX_PW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_WARPS; i++) begin
      cnt = cnt + MAX_PW'(bits[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/vx_warp_perf_tracker_if.sv
// vx_warp_perf_tracker_if
//   Scheduler-side observation bus sampled by the tracker every cycle.
//   active_mask  : warps currently active
//   stalled_mask : warps blocked this cycle
//   sched_valid  : scheduler presents a warp
//   sched_ready  : downstream accepts the warp
//   master modport drives the bus (scheduler side), slave modport observes it.
interface vx_warp_perf_tracker_if #(
  parameter int unsigned NUM_WARPS = 8
);

  logic [NUM_WARPS-1:0] active_mask;
  logic [NUM_WARPS-1:0] stalled_mask;
  logic                 sched_valid;
  logic                 sched_ready;

  modport master (
    output active_mask,
    output stalled_mask,
    output sched_valid,
    output sched_ready
  );

  modport slave (
    input active_mask,
    input stalled_mask,
    input sched_valid,
    input sched_ready
  );

endinterface

// File: rtl/vx_warp_perf_tracker_sat_accum.sv
// vx_warp_perf_tracker_sat_accum
//   Accumulator that either wraps modulo 2^WIDTH or clamps at all-ones.
//   clk, reset : clock and synchronous active-high reset
//   enable     : add inc this cycle
//   clear      : zero the accumulator (beats enable)
//   inc        : unsigned increment
//   value      : current accumulated value
//   sum        : value + inc after wrap/clamp, i.e. what an enabled cycle would store
module vx_warp_perf_tracker_sat_accum #(
  parameter int unsigned WIDTH     = 44,
  parameter int unsigned INC_WIDTH = 4,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [INC_WIDTH-1:0] inc,
  output logic [WIDTH-1:0]     value,
  output logic [WIDTH-1:0]     sum
);

  // One spare bit above the wider operand catches any carry out of WIDTH.
  localparam int unsigned SW = ((WIDTH > INC_WIDTH) ? WIDTH : INC_WIDTH) + 1;

  logic [WIDTH-1:0] value_q, value_d;
  logic [SW-1:0]    wide_sum;
  logic             overflow;

  assign wide_sum = SW'(value_q) + SW'(inc);
  assign overflow = |wide_sum[SW-1:WIDTH];
  assign sum      = (SATURATE && overflow) ? '1 : wide_sum[WIDTH-1:0];
  assign value    = value_q;

  always_comb begin
    value_d = value_q;
    if (clear) begin
      value_d = '0;
    end else if (enable) begin
      value_d = sum;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/vx_warp_perf_tracker.sv
// vx_warp_perf_tracker
//   Per-core scheduler/warp performance accumulator. Samples the warp masks and the
//   scheduler handshake, then adds the sampled cycle's popcounts into lifetime totals
//   and into windowed totals one cycle later (input-to-total latency of 2).
//   clk, reset    : core clock, synchronous active-high reset
//   sched_if      : slave view of active/stalled masks and sched_valid/sched_ready
//   clear         : zero all counters, window state and in-flight sample
//   freeze        : hold counters, accumulators, peak and window timer
//   sched_idles   : cycles with sched_valid=0
//   sched_stalls  : cycles with sched_valid=1 and sched_ready=0
//   active_warps  : sum of popcount(active_mask)
//   stalled_warps : sum of popcount(active_mask & stalled_mask)
//   win_active    : active sum over the last completed window
//   win_stalled   : stalled sum over the last completed window
//   win_peak      : max popcount(active_mask) over the last completed window
//   win_valid     : one-cycle pulse when win_* update
module vx_warp_perf_tracker
  import vx_warp_perf_tracker_pkg::*;
#(
  parameter int unsigned NUM_WARPS     = 8,
  parameter int unsigned CTR_BITS      = 44,
  parameter int unsigned WIN_CTR_BITS  = 32,
  parameter int unsigned WINDOW_CYCLES = 1024,
  parameter bit          SATURATE      = 1'b0
) (
  input  logic                             clk,
  input  logic                             reset,
  vx_warp_perf_tracker_if.slave            sched_if,
  input  logic                             clear,
  input  logic                             freeze,
  output logic [CTR_BITS-1:0]              sched_idles,
  output logic [CTR_BITS-1:0]              sched_stalls,
  output logic [CTR_BITS-1:0]              active_warps,
  output logic [CTR_BITS-1:0]              stalled_warps,
  output logic [WIN_CTR_BITS-1:0]          win_active,
  output logic [WIN_CTR_BITS-1:0]          win_stalled,
  output logic [$clog2(NUM_WARPS+1)-1:0]   win_peak,
  output logic                             win_valid
);

  // NUM_WARPS is limited to MAX_WARPS by the popcount helper.
  localparam int unsigned PW     = pop_width(NUM_WARPS);
  localparam bit          WIN_EN = (WINDOW_CYCLES != 0);
  localparam int unsigned TW     = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int unsigned LAST   = WIN_EN ? (WINDOW_CYCLES - 1) : 0;

  logic                 s_valid_q, s_valid_d;
  logic [NUM_WARPS-1:0] s_active_q, s_active_d;
  logic [NUM_WARPS-1:0] s_stalled_q, s_stalled_d;
  logic                 s_sched_valid_q, s_sched_valid_d;
  logic                 s_sched_ready_q, s_sched_ready_d;

  // Stage 1: a sample taken while frozen or clearing is marked invalid and never counted.
  always_comb begin
    s_valid_d       = ~freeze & ~clear;
    s_active_d      = sched_if.active_mask;
    s_stalled_d     = sched_if.stalled_mask;
    s_sched_valid_d = sched_if.sched_valid;
    s_sched_ready_d = sched_if.sched_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_valid_q       <= 1'b0;
      s_active_q      <= '0;
      s_stalled_q     <= '0;
      s_sched_valid_q <= 1'b0;
      s_sched_ready_q <= 1'b0;
    end else begin
      s_valid_q       <= s_valid_d;
      s_active_q      <= s_active_d;
      s_stalled_q     <= s_stalled_d;
      s_sched_valid_q <= s_sched_valid_d;
      s_sched_ready_q <= s_sched_ready_d;
    end
  end

  // Stage 2: stall bits of inactive warps are masked off before counting.
  perf_inc_t     inc_s;
  logic [PW-1:0] active_inc, stalled_inc;
  logic          count_en, win_en, win_end;

  always_comb begin
    inc_s         = '0;
    inc_s.idle    = ~s_sched_valid_q;
    inc_s.stall   = s_sched_valid_q & ~s_sched_ready_q;
    inc_s.active  = popcount(MAX_WARPS'(s_active_q));
    inc_s.stalled = popcount(MAX_WARPS'(s_active_q & s_stalled_q));
  end

  assign active_inc  = PW'(inc_s.active);
  assign stalled_inc = PW'(inc_s.stalled);
  assign count_en    = s_valid_q & ~freeze;
  assign win_en      = WIN_EN && count_en;

  logic [TW-1:0] timer_q, timer_d;
  logic [PW-1:0] peak_q, peak_d, peak_max;

  assign win_end  = win_en && (timer_q == TW'(LAST));
  assign peak_max = (active_inc > peak_q) ? active_inc : peak_q;

  logic [CTR_BITS-1:0]     idle_sum, stall_sum, active_sum, stalled_sum;
  logic [WIN_CTR_BITS-1:0] win_act_value, win_stl_value, win_act_sum, win_stl_sum;

  vx_warp_perf_tracker_sat_accum #(.WIDTH(CTR_BITS), .INC_WIDTH(1), .SATURATE(SATURATE)) u_idles (
    .clk(clk), .reset(reset), .enable(count_en), .clear(clear),
    .inc(inc_s.idle), .value(sched_idles), .sum(idle_sum)
  );

  vx_warp_perf_tracker_sat_accum #(.WIDTH(CTR_BITS), .INC_WIDTH(1), .SATURATE(SATURATE)) u_stalls (
    .clk(clk), .reset(reset), .enable(count_en), .clear(clear),
    .inc(inc_s.stall), .value(sched_stalls), .sum(stall_sum)
  );

  vx_warp_perf_tracker_sat_accum #(.WIDTH(CTR_BITS), .INC_WIDTH(PW), .SATURATE(SATURATE)) u_active (
    .clk(clk), .reset(reset), .enable(count_en), .clear(clear),
    .inc(active_inc), .value(active_warps), .sum(active_sum)
  );

  vx_warp_perf_tracker_sat_accum #(.WIDTH(CTR_BITS), .INC_WIDTH(PW), .SATURATE(SATURATE)) u_stalled (
    .clk(clk), .reset(reset), .enable(count_en), .clear(clear),
    .inc(stalled_inc), .value(stalled_warps), .sum(stalled_sum)
  );

  // Window accumulators restart at a window end; their sum output already holds the
  // current cycle's increment, which is what the published window must include.
  vx_warp_perf_tracker_sat_accum #(.WIDTH(WIN_CTR_BITS), .INC_WIDTH(PW), .SATURATE(SATURATE)) u_win_act (
    .clk(clk), .reset(reset), .enable(win_en), .clear(clear | win_end),
    .inc(active_inc), .value(win_act_value), .sum(win_act_sum)
  );

  vx_warp_perf_tracker_sat_accum #(.WIDTH(WIN_CTR_BITS), .INC_WIDTH(PW), .SATURATE(SATURATE)) u_win_stl (
    .clk(clk), .reset(reset), .enable(win_en), .clear(clear | win_end),
    .inc(stalled_inc), .value(win_stl_value), .sum(win_stl_sum)
  );

  logic unused_sums;
  assign unused_sums = ^{idle_sum, stall_sum, active_sum, stalled_sum, win_act_value, win_stl_value};

  logic [WIN_CTR_BITS-1:0] win_active_q, win_active_d;
  logic [WIN_CTR_BITS-1:0] win_stalled_q, win_stalled_d;
  logic [PW-1:0]           win_peak_q, win_peak_d;
  logic                    win_valid_q, win_valid_d;

  // Window timer, running peak and published window results; clear beats window end.
  always_comb begin
    timer_d       = timer_q;
    peak_d        = peak_q;
    win_active_d  = win_active_q;
    win_stalled_d = win_stalled_q;
    win_peak_d    = win_peak_q;
    win_valid_d   = 1'b0;
    if (clear) begin
      timer_d       = '0;
      peak_d        = '0;
      win_active_d  = '0;
      win_stalled_d = '0;
      win_peak_d    = '0;
    end else if (win_end) begin
      timer_d       = '0;
      peak_d        = '0;
      win_active_d  = win_act_sum;
      win_stalled_d = win_stl_sum;
      win_peak_d    = peak_max;
      win_valid_d   = 1'b1;
    end else if (win_en) begin
      timer_d = timer_q + TW'(1);
      peak_d  = peak_max;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q       <= '0;
      peak_q        <= '0;
      win_active_q  <= '0;
      win_stalled_q <= '0;
      win_peak_q    <= '0;
      win_valid_q   <= 1'b0;
    end else begin
      timer_q       <= timer_d;
      peak_q        <= peak_d;
      win_active_q  <= win_active_d;
      win_stalled_q <= win_stalled_d;
      win_peak_q    <= win_peak_d;
      win_valid_q   <= win_valid_d;
    end
  end

  assign win_active  = win_active_q;
  assign win_stalled = win_stalled_q;
  assign win_peak    = win_peak_q;
  assign win_valid   = win_valid_q;

endmodule

// File: tb/tb_vx_warp_perf_tracker.sv
// tb_vx_warp_perf_tracker
//   Drives one shared scheduler bus into three tracker configurations:
//   a: 44-bit wrapping totals, 4-cycle window
//   b: 4-bit saturating totals, 5-bit saturating 8-cycle window
//   c: 4-bit wrapping totals, windowing disabled
//   A count-level reference model predicts every output after each clock.
module tb_vx_warp_perf_tracker;

  logic clk = 1'b0;
  logic reset, clear, freeze;

  always #5 clk = ~clk;

  vx_warp_perf_tracker_if #(.NUM_WARPS(8)) sched_bus ();

  logic [43:0] a_idles, a_stalls, a_active, a_stalled;
  logic [31:0] a_win_active, a_win_stalled;
  logic [3:0]  a_win_peak;
  logic        a_win_valid;
  logic [3:0]  b_idles, b_stalls, b_active, b_stalled;
  logic [4:0]  b_win_active, b_win_stalled;
  logic [3:0]  b_win_peak;
  logic        b_win_valid;
  logic [3:0]  c_idles, c_stalls, c_active, c_stalled;
  logic [31:0] c_win_active, c_win_stalled;
  logic [3:0]  c_win_peak;
  logic        c_win_valid;

  vx_warp_perf_tracker #(.NUM_WARPS(8), .CTR_BITS(44), .WIN_CTR_BITS(32), .WINDOW_CYCLES(4), .SATURATE(1'b0)) dut_a (
    .clk(clk), .reset(reset), .sched_if(sched_bus), .clear(clear), .freeze(freeze),
    .sched_idles(a_idles), .sched_stalls(a_stalls), .active_warps(a_active), .stalled_warps(a_stalled),
    .win_active(a_win_active), .win_stalled(a_win_stalled), .win_peak(a_win_peak), .win_valid(a_win_valid)
  );

  vx_warp_perf_tracker #(.NUM_WARPS(8), .CTR_BITS(4), .WIN_CTR_BITS(5), .WINDOW_CYCLES(8), .SATURATE(1'b1)) dut_b (
    .clk(clk), .reset(reset), .sched_if(sched_bus), .clear(clear), .freeze(freeze),
    .sched_idles(b_idles), .sched_stalls(b_stalls), .active_warps(b_active), .stalled_warps(b_stalled),
    .win_active(b_win_active), .win_stalled(b_win_stalled), .win_peak(b_win_peak), .win_valid(b_win_valid)
  );

  vx_warp_perf_tracker #(.NUM_WARPS(8), .CTR_BITS(4), .WIN_CTR_BITS(32), .WINDOW_CYCLES(0), .SATURATE(1'b0)) dut_c (
    .clk(clk), .reset(reset), .sched_if(sched_bus), .clear(clear), .freeze(freeze),
    .sched_idles(c_idles), .sched_stalls(c_stalls), .active_warps(c_active), .stalled_warps(c_stalled),
    .win_active(c_win_active), .win_stalled(c_win_stalled), .win_peak(c_win_peak), .win_valid(c_win_valid)
  );

  int errors = 0;
  int checks = 0;

  int unsigned cfg_ctr [3] = '{44, 4, 4};
  int unsigned cfg_win [3] = '{32, 5, 32};
  int unsigned cfg_wc  [3] = '{4, 8, 0};
  bit          cfg_sat [3] = '{1'b0, 1'b1, 1'b0};

  // Model state: exact unbounded totals, reduced to the counter width only when compared.
  longint unsigned m_tot   [3][4];
  longint unsigned w_sum_a [3];
  longint unsigned w_sum_s [3];
  longint unsigned w_max   [3];
  int unsigned     w_cnt   [3];
  longint unsigned m_win_a [3];
  longint unsigned m_win_s [3];
  longint unsigned m_win_p [3];
  bit              m_wv    [3];

  // The sample captured at the previous edge, waiting to be counted.
  bit         st_valid = 1'b0;
  logic [7:0] st_act   = '0;
  logic [7:0] st_stl   = '0;
  logic       st_v     = 1'b0;
  logic       st_r     = 1'b0;

  function automatic longint unsigned fit(input longint unsigned v, input int unsigned w, input bit sat);
    longint unsigned lim;
    lim = (64'd1 << w) - 64'd1;
    if (sat) return (v > lim) ? lim : v;
    return v & lim;
  endfunction

  function automatic longint unsigned exp_tot(input int d, input int k);
    return fit(m_tot[d][k], cfg_ctr[d], cfg_sat[d]);
  endfunction

  // Advances the model across one clock edge given the inputs present before that edge.
  task automatic model_step(input logic rst, input logic clr, input logic frz,
                            input logic [7:0] act, input logic [7:0] stl,
                            input logic v, input logic r);
    longint unsigned na, ns;
    na = 64'($countones(st_act));
    ns = 64'($countones(st_act & st_stl));
    for (int d = 0; d < 3; d++) begin
      if (rst || clr) begin
        for (int k = 0; k < 4; k++) m_tot[d][k] = 0;
        w_sum_a[d] = 0; w_sum_s[d] = 0; w_max[d] = 0; w_cnt[d] = 0;
        m_win_a[d] = 0; m_win_s[d] = 0; m_win_p[d] = 0; m_wv[d] = 1'b0;
      end else begin
        m_wv[d] = 1'b0;
        if (st_valid && !frz) begin
          m_tot[d][0] += st_v ? 64'd0 : 64'd1;
          m_tot[d][1] += (st_v && !st_r) ? 64'd1 : 64'd0;
          m_tot[d][2] += na;
          m_tot[d][3] += ns;
          if (cfg_wc[d] != 0) begin
            w_sum_a[d] += na;
            w_sum_s[d] += ns;
            if (na > w_max[d]) w_max[d] = na;
            w_cnt[d]++;
            if (w_cnt[d] == cfg_wc[d]) begin
              m_win_a[d] = fit(w_sum_a[d], cfg_win[d], cfg_sat[d]);
              m_win_s[d] = fit(w_sum_s[d], cfg_win[d], cfg_sat[d]);
              m_win_p[d] = w_max[d];
              m_wv[d]    = 1'b1;
              w_sum_a[d] = 0; w_sum_s[d] = 0; w_max[d] = 0; w_cnt[d] = 0;
            end
          end
        end
      end
    end
    st_valid = !rst && !clr && !frz;
    st_act   = act;
    st_stl   = stl;
    st_v     = v;
    st_r     = r;
  endtask

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string step);
    checkVal({step, " a.idles"},       64'(a_idles),       exp_tot(0, 0));
    checkVal({step, " a.stalls"},      64'(a_stalls),      exp_tot(0, 1));
    checkVal({step, " a.active"},      64'(a_active),      exp_tot(0, 2));
    checkVal({step, " a.stalled"},     64'(a_stalled),     exp_tot(0, 3));
    checkVal({step, " a.win_active"},  64'(a_win_active),  m_win_a[0]);
    checkVal({step, " a.win_stalled"}, 64'(a_win_stalled), m_win_s[0]);
    checkVal({step, " a.win_peak"},    64'(a_win_peak),    m_win_p[0]);
    checkVal({step, " a.win_valid"},   64'(a_win_valid),   64'(m_wv[0]));
    checkVal({step, " b.idles"},       64'(b_idles),       exp_tot(1, 0));
    checkVal({step, " b.stalls"},      64'(b_stalls),      exp_tot(1, 1));
    checkVal({step, " b.active"},      64'(b_active),      exp_tot(1, 2));
    checkVal({step, " b.stalled"},     64'(b_stalled),     exp_tot(1, 3));
    checkVal({step, " b.win_active"},  64'(b_win_active),  m_win_a[1]);
    checkVal({step, " b.win_stalled"}, 64'(b_win_stalled), m_win_s[1]);
    checkVal({step, " b.win_peak"},    64'(b_win_peak),    m_win_p[1]);
    checkVal({step, " b.win_valid"},   64'(b_win_valid),   64'(m_wv[1]));
    checkVal({step, " c.idles"},       64'(c_idles),       exp_tot(2, 0));
    checkVal({step, " c.stalls"},      64'(c_stalls),      exp_tot(2, 1));
    checkVal({step, " c.active"},      64'(c_active),      exp_tot(2, 2));
    checkVal({step, " c.stalled"},     64'(c_stalled),     exp_tot(2, 3));
    checkVal({step, " c.win_active"},  64'(c_win_active),  64'd0);
    checkVal({step, " c.win_stalled"}, 64'(c_win_stalled), 64'd0);
    checkVal({step, " c.win_peak"},    64'(c_win_peak),    64'd0);
    checkVal({step, " c.win_valid"},   64'(c_win_valid),   64'd0);
  endtask

  task automatic applyStimulus(input string step, input logic [7:0] act, input logic [7:0] stl,
                               input logic v, input logic r, input logic clr, input logic frz);
    sched_bus.active_mask  = act;
    sched_bus.stalled_mask = stl;
    sched_bus.sched_valid  = v;
    sched_bus.sched_ready  = r;
    clear  = clr;
    freeze = frz;
    @(posedge clk);
    model_step(reset, clr, frz, act, stl, v, r);
    #1;
    checkOutput(step);
  endtask

  task automatic applyReset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) applyStimulus("reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  logic [7:0] win_masks [4] = '{8'h01, 8'h07, 8'h03, 8'h1F};
  int pulses;

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    freeze = 1'b0;
    sched_bus.active_mask  = '0;
    sched_bus.stalled_mask = '0;
    sched_bus.sched_valid  = 1'b0;
    sched_bus.sched_ready  = 1'b0;
    applyReset(2);

    for (int i = 0; i < 10; i++) applyStimulus("full", 8'hFF, 8'h0F, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++)  applyStimulus("flush", 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    checkVal("ten_full active", 64'(a_active), 64'd80);
    checkVal("ten_full stalled", 64'(a_stalled), 64'd40);

    applyStimulus("clear", 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus("masked", 8'h03, 8'hF0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus("flush", 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    checkVal("masked stalled", 64'(a_stalled), 64'd0);
    checkVal("masked active", 64'(a_active), 64'd10);

    applyStimulus("clear", 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("idle", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus("stall", 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus("accept", 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    checkVal("handshake idles", 64'(a_idles), 64'd3);
    checkVal("handshake stalls", 64'(a_stalls), 64'd4);

    applyStimulus("clear", 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      applyStimulus("window", (i < 4) ? win_masks[i] : 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
      if (a_win_valid === 1'b1) pulses++;
    end
    checkVal("window pulses", 64'(pulses), 64'd1);
    checkVal("window active", 64'(a_win_active), 64'd11);
    checkVal("window peak", 64'(a_win_peak), 64'd5);

    applyStimulus("clear", 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("sat", 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus("flush", 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    checkVal("saturate active", 64'(b_active), 64'd15);
    checkVal("wrap active", 64'(c_active), 64'd8);

    applyStimulus("clear", 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("prefreeze", 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus("frozen", 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    checkVal("frozen active", 64'(a_active), 64'd16);
    for (int i = 0; i < 2; i++) applyStimulus("thaw", 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus("clear_at_end", 8'hFF, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    checkVal("clear_at_end active", 64'(a_active), 64'd0);
    checkVal("clear_at_end pulse", 64'(a_win_valid), 64'd0);
    applyStimulus("after_clear", 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    checkVal("after_clear pulse", 64'(a_win_valid), 64'd0);

    for (int i = 0; i < 80; i++) begin
      applyStimulus("random", 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                    ($urandom_range(0, 29) == 0), ($urandom_range(0, 9) == 0));
    end

    for (int i = 0; i < 2; i++) applyStimulus("partial", 8'hFF, 8'h0F, 1'b1, 1'b1, 1'b0, 1'b0);
    applyReset(1);
    for (int i = 0; i < 3; i++) applyStimulus("post_reset", 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    checkVal("post_reset win_active", 64'(a_win_active), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
